// File: rtl/exp_1x1_ctrl_pkg.sv
// Shared definitions for the expand 1x1 convolution sequencer.
// Holds FSM encodings, datapath depth constants, kernel word packing
// offsets and a saturating-increment helper.
package exp_1x1_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int EXP_FIFO_DEPTH = 256;
    localparam int EXP_PIPE_LAT   = 4;

    // Kernel word packing: kernel_1 sits in the top byte.
    localparam int K1_LSB = 24;
    localparam int K2_LSB = 16;
    localparam int K3_LSB = 8;
    localparam int K4_LSB = 0;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [7:0] kernel_lane(
        input logic [31:0] word,
        input int          lsb
    );
        return word[lsb +: 8];
    endfunction

endpackage

// File: rtl/exp_1x1_ctrl_addr_gen.sv
// Nested grp/ch/pix beat counters and kernel RAM address for the
// expand 1x1 sequencer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               zero all counters (new layer)
//   advance             one beat issued this cycle
//   num_pix/ch/grp      latched layer geometry
//   addr                kernel RAM address grp*num_ch + ch
//   last_grp            current beat is the last group of its activation
//   last_beat           current beat is the final beat of the layer
module exp_1x1_ctrl_addr_gen
    import exp_1x1_ctrl_pkg::*;
#(
    parameter int KADDR_W = 10,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    input  logic [CNT_W-1:0]   num_pix,
    input  logic [CNT_W-1:0]   num_ch,
    input  logic [CNT_W-1:0]   num_grp,
    output logic [KADDR_W-1:0] addr,
    output logic               last_grp,
    output logic               last_beat
);

    logic [CNT_W-1:0] grp;
    logic [CNT_W-1:0] ch;
    logic [CNT_W-1:0] pix;
    logic             last_ch;
    logic             last_pix;

    assign last_grp = (grp == num_grp - CNT_W'(1));
    assign last_ch  = (ch  == num_ch  - CNT_W'(1));
    assign last_pix = (pix == num_pix - CNT_W'(1));

    assign last_beat = last_grp && last_ch && last_pix;

    // Low bits of a product only depend on low bits of the operands,
    // so truncating first gives the same wrapped address.
    assign addr = KADDR_W'(grp) * KADDR_W'(num_ch) + KADDR_W'(ch);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            grp <= '0;
            ch  <= '0;
            pix <= '0;
        end else if (advance) begin
            if (!last_grp) begin
                grp <= grp + CNT_W'(1);
            end else begin
                grp <= '0;
                if (!last_ch) begin
                    ch <= ch + CNT_W'(1);
                end else begin
                    ch <= '0;
                    if (last_pix) begin
                        pix <= '0;
                    end else begin
                        pix <= pix + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/exp_1x1_ctrl.sv
// Sequencer for the expand 1x1 convolution datapath: pulls activations,
// fetches packed kernel words and issues operand beats throttled by FIFO fill.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_i, cfg_num_*_i          layer start and geometry (sampled in IDLE)
//   busy_o, done_o                layer in progress / 1-cycle completion pulse
//   layer_valid_i/data_i/ready_o  activation stream handshake
//   kram_addr_o/rd_en_o/data_i    kernel RAM port (1-cycle read latency)
//   conv_start_o                  clears the datapath at layer start
//   conv_layer_data_o             activation operand
//   conv_kernal_data_o            {k1,k2,k3,k4} kernel operands
//   conv_data_flag_o              operand beat valid
//   fifo_count_i                  datapath output FIFO usedw
//   stall_cnt_o                   FIFO-stalled RUN cycles
//                                 (only with EXP1X1_CTRL_STALL_CNT_EN)
module exp_1x1_ctrl
    import exp_1x1_ctrl_pkg::*;
#(
    parameter int KADDR_W     = 10,
    parameter int CNT_W       = 16,
    parameter int FIFO_HI_THR = 248,
    parameter int PIPE_LAT    = EXP_PIPE_LAT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   cfg_num_pix_i,
    input  logic [CNT_W-1:0]   cfg_num_ch_i,
    input  logic [CNT_W-1:0]   cfg_num_grp_i,
    output logic               busy_o,
    output logic               done_o,
    input  logic               layer_valid_i,
    input  logic [7:0]         layer_data_i,
    output logic               layer_ready_o,
    output logic [KADDR_W-1:0] kram_addr_o,
    output logic               kram_rd_en_o,
    input  logic [31:0]        kram_data_i,
    output logic               conv_start_o,
    output logic [7:0]         conv_layer_data_o,
    output logic [31:0]        conv_kernal_data_o,
    output logic               conv_data_flag_o,
    input  logic [7:0]         fifo_count_i
`ifdef EXP1X1_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);

    localparam int THR_W = $clog2(EXP_FIFO_DEPTH) + 1;
    localparam logic [THR_W-1:0] THR = THR_W'(FIFO_HI_THR);
    localparam int DW = $clog2(PIPE_LAT) + 1;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]   num_pix;
    logic [CNT_W-1:0]   num_ch;
    logic [CNT_W-1:0]   num_grp;
    logic [7:0]         act;
    logic [7:0]         act_s1;
    logic [31:0]        kern_hold;
    logic [DW-1:0]      drain_cnt;
    logic [KADDR_W-1:0] addr;
    logic               last_grp;
    logic               last_beat;
    logic               stall;
    logic               issue;
    logic               start_ok;
    logic               cfg_zero;
    logic               take;

    assign stall    = THR_W'(fifo_count_i) >= THR;
    assign start_ok = (state == ST_IDLE) && start_i;
    assign cfg_zero = (cfg_num_pix_i == '0) ||
                      (cfg_num_ch_i  == '0) ||
                      (cfg_num_grp_i == '0);
    assign take     = layer_valid_i && layer_ready_o;

    exp_1x1_ctrl_addr_gen #(
        .KADDR_W (KADDR_W),
        .CNT_W   (CNT_W)
    ) u_addr_gen (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (start_ok),
        .advance   (issue),
        .num_pix   (num_pix),
        .num_ch    (num_ch),
        .num_grp   (num_grp),
        .addr      (addr),
        .last_grp  (last_grp),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        layer_ready_o = 1'b0;
        issue         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = cfg_zero ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                layer_ready_o = 1'b1;
                if (layer_valid_i) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (last_beat) begin
                        state_nxt = ST_DRAIN;
                    end else if (last_grp) begin
                        // Pull the next activation alongside the last
                        // group so consecutive values run without a gap.
                        layer_ready_o = 1'b1;
                        if (!layer_valid_i) begin
                            state_nxt = ST_LOAD;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DW'(PIPE_LAT - 1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            num_pix           <= '0;
            num_ch            <= '0;
            num_grp           <= '0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            conv_start_o      <= 1'b0;
            act               <= '0;
            act_s1            <= '0;
            drain_cnt         <= '0;
            kram_rd_en_o      <= 1'b0;
            kram_addr_o       <= '0;
            conv_data_flag_o  <= 1'b0;
            conv_layer_data_o <= '0;
            kern_hold         <= '0;
        end else begin
            conv_start_o <= start_ok;
            if (start_ok) begin
                num_pix <= cfg_num_pix_i;
                num_ch  <= cfg_num_ch_i;
                num_grp <= cfg_num_grp_i;
                busy_o  <= 1'b1;
            end
            if (state == ST_DONE) begin
                done_o <= 1'b1;
                busy_o <= 1'b0;
            end else begin
                done_o <= 1'b0;
            end
            if (take) begin
                act <= layer_data_i;
            end
            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + DW'(1);
            end else begin
                drain_cnt <= '0;
            end
            // Stage 1: RAM read issue; activation travels with it.
            kram_rd_en_o <= issue;
            if (issue) begin
                kram_addr_o <= addr;
                act_s1      <= act;
            end
            // Stage 2: flag lines up with RAM read data.
            conv_data_flag_o <= kram_rd_en_o;
            if (kram_rd_en_o) begin
                conv_layer_data_o <= act_s1;
            end
            if (conv_data_flag_o) begin
                kern_hold <= kram_data_i;
            end
        end
    end

    // RAM output is already registered; pass it through on a beat and
    // hold the last beat's word otherwise.
    assign conv_kernal_data_o = conv_data_flag_o ? kram_data_i : kern_hold;

`ifdef EXP1X1_CTRL_STALL_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok) begin
            stall_cnt_o <= '0;
        end else if ((state == ST_RUN) && stall) begin
            stall_cnt_o <= sat_inc32(stall_cnt_o);
        end
    end
`endif

endmodule

// File: tb/tb_exp_1x1_ctrl.sv
// Scoreboard bench for exp_1x1_ctrl: expected reads and operand beats are
// queued by stimulus and popped by an independent negedge monitor.
module tb_exp_1x1_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] cfg_num_pix_i;
    logic [15:0] cfg_num_ch_i;
    logic [15:0] cfg_num_grp_i;
    logic        busy_o;
    logic        done_o;
    logic        layer_valid_i;
    logic [7:0]  layer_data_i;
    logic        layer_ready_o;
    logic [9:0]  kram_addr_o;
    logic        kram_rd_en_o;
    logic [31:0] kram_data_i = '0;
    logic        conv_start_o;
    logic [7:0]  conv_layer_data_o;
    logic [31:0] conv_kernal_data_o;
    logic        conv_data_flag_o;
    logic [7:0]  fifo_count_i;
`ifdef EXP1X1_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int flags_layer = 0;
    int last_flag = 0;
    bit chk_en = 1'b1;
    bit prev_hi = 1'b0;

    logic [9:0]  exp_addr[$];
    logic [39:0] exp_op[$];

    always #5 clk = ~clk;

    exp_1x1_ctrl dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .start_i            (start_i),
        .cfg_num_pix_i      (cfg_num_pix_i),
        .cfg_num_ch_i       (cfg_num_ch_i),
        .cfg_num_grp_i      (cfg_num_grp_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .layer_valid_i      (layer_valid_i),
        .layer_data_i       (layer_data_i),
        .layer_ready_o      (layer_ready_o),
        .kram_addr_o        (kram_addr_o),
        .kram_rd_en_o       (kram_rd_en_o),
        .kram_data_i        (kram_data_i),
        .conv_start_o       (conv_start_o),
        .conv_layer_data_o  (conv_layer_data_o),
        .conv_kernal_data_o (conv_kernal_data_o),
        .conv_data_flag_o   (conv_data_flag_o),
        .fifo_count_i       (fifo_count_i)
`ifdef EXP1X1_CTRL_STALL_CNT_EN
        ,
        .stall_cnt_o        (stall_cnt_o)
`endif
    );

    function automatic logic [31:0] krom(input logic [9:0] a);
        return {a[7:0], a[7:0] + 8'h40, ~a[7:0], a[7:0] ^ 8'h5A};
    endfunction

    // Kernel RAM model: registered read.
    always @(posedge clk) begin
        if (kram_rd_en_o) kram_data_i <= krom(kram_addr_o);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [9:0]  a;
        logic [39:0] o;
        cyc++;
        if (rst_i || !chk_en) begin
            prev_hi = 1'b0;
        end else begin
            if (prev_hi) chk("stall_no_rd", kram_rd_en_o, 0);
            if (kram_rd_en_o) begin
                if (exp_addr.size() == 0) begin
                    chk("unexpected_rd", kram_rd_en_o, 0);
                end else begin
                    a = exp_addr.pop_front();
                    chk("kram_addr", kram_addr_o, a);
                end
            end
            if (conv_data_flag_o) begin
                flags_layer++;
                last_flag = cyc;
                if (exp_op.size() == 0) begin
                    chk("unexpected_flag", conv_data_flag_o, 0);
                end else begin
                    o = exp_op.pop_front();
                    chk("operands", {conv_layer_data_o, conv_kernal_data_o}, o);
                end
            end
            if (done_o && flags_layer > 0) chk("done_latency", cyc - last_flag, 4);
            prev_hi = (fifo_count_i >= 8'd248);
        end
        if (conv_start_o) flags_layer = 0;
    end

    task automatic feed(input logic [7:0] v);
        int n = 0;
        layer_valid_i = 1'b1;
        layer_data_i  = v;
        @(negedge clk);
        while (!layer_ready_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!layer_ready_o) chk("feed_ready", layer_ready_o, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_layer(input int p, input int c, input int g,
                             input int gap_after, input int stall_at);
        logic [9:0] a;
        logic [7:0] v;
        int n;
        bit seen;
        for (int pi = 0; pi < p; pi++)
            for (int ci = 0; ci < c; ci++) begin
                v = 8'(17 * (pi * c + ci + 1));
                for (int gi = 0; gi < g; gi++) begin
                    a = 10'(gi * c + ci);
                    exp_addr.push_back(a);
                    exp_op.push_back({v, krom(a)});
                end
            end
        cfg_num_pix_i = 16'(p);
        cfg_num_ch_i  = 16'(c);
        cfg_num_grp_i = 16'(g);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("start_pulse", conv_start_o, 1);
        chk("busy_after_start", busy_o, 1);
`ifdef EXP1X1_CTRL_STALL_CNT_EN
        chk("stall_cnt_cleared", stall_cnt_o, 0);
`endif
        @(posedge clk); #1;
        fork
            begin
                for (int idx = 0; idx < p * c; idx++) begin
                    feed(8'(17 * (idx + 1)));
                    if (idx == gap_after) begin
                        layer_valid_i = 1'b0;
                        for (int i = 0; i < 5; i++) begin
                            @(negedge clk);
                            if (i >= 3) chk("load_ready", layer_ready_o, 1);
                            if (i == 4) chk("load_no_rd", kram_rd_en_o, 0);
                            @(posedge clk); #1;
                        end
                    end
                end
                layer_valid_i = 1'b0;
            end
            begin
                if (stall_at > 0) begin
                    repeat (stall_at) @(posedge clk);
                    #1 fifo_count_i = 8'd248;
                    repeat (10) @(posedge clk);
                    #1 fifo_count_i = 8'd247;
                end
            end
        join
        n = 0;
        seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            seen = done_o;
            n++;
        end
        chk("done_seen", seen, 1);
        chk("busy_at_done", busy_o, 0);
        chk("beat_count", flags_layer, p * c * g);
        chk("queues_empty", exp_addr.size() + exp_op.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        cfg_num_pix_i = '0;
        cfg_num_ch_i = '0;
        cfg_num_grp_i = '0;
        layer_valid_i = 1'b0;
        layer_data_i = '0;
        fifo_count_i = 8'd247;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {busy_o, done_o, layer_ready_o, kram_addr_o,
            kram_rd_en_o, conv_start_o, conv_layer_data_o,
            conv_kernal_data_o, conv_data_flag_o}, 0);
        @(posedge clk); #1;

        // Abort mid-RUN with a 3-cycle reset.
        chk_en = 1'b0;
        cfg_num_pix_i = 16'd4;
        cfg_num_ch_i = 16'd2;
        cfg_num_grp_i = 16'd2;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        layer_valid_i = 1'b1;
        layer_data_i = 8'h77;
        repeat (6) @(posedge clk);
        #1 rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        layer_valid_i = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {busy_o, done_o, layer_ready_o, kram_addr_o,
            kram_rd_en_o, conv_start_o, conv_layer_data_o,
            conv_kernal_data_o, conv_data_flag_o}, 0);
        exp_addr.delete();
        exp_op.delete();
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Small layer, back-to-back: addrs 0,3,1,4,2,5 twice.
        run_layer(2, 3, 2, -1, 0);

        // Backpressure for 10 cycles mid-RUN.
        run_layer(2, 3, 2, -1, 5);
`ifdef EXP1X1_CTRL_STALL_CNT_EN
        chk("stall_cnt_after_done", stall_cnt_o, 10);
`endif

        // Starved input: 5 idle cycles after the second value.
        run_layer(2, 2, 3, 1, 0);

        // Single group per activation.
        run_layer(1, 4, 1, -1, 0);

        // Zero config: no beats, done 2 cycles after start.
        cfg_num_pix_i = 16'd3;
        cfg_num_ch_i = 16'd0;
        cfg_num_grp_i = 16'd2;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("zero_start_pulse", conv_start_o, 1);
        chk("zero_done_early", done_o, 0);
        @(negedge clk);
        chk("zero_done", done_o, 1);
        chk("zero_busy", busy_o, 0);
        chk("zero_beats", flags_layer, 0);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
